// File: rtl/adc_frame_streamer_pkg.sv
// rtl/adc_frame_streamer_pkg.sv - framing constants, opcodes and FSM encoding for adc_frame_streamer
package adc_frame_streamer_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam logic [7:0] SEL_ALL     = 8'hFF;

    localparam logic [7:0] CMD_CH_BASE = 8'h31;
    localparam logic [7:0] CMD_ALL     = 8'h41;
    localparam logic [7:0] CMD_START   = 8'h53;
    localparam logic [7:0] CMD_STOP    = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

endpackage

// File: rtl/adc_frame_streamer_uart_byte_handshake.sv
// rtl/adc_frame_streamer_uart_byte_handshake.sv - one-byte write strobe / tx_ready handshake toward a UART TX
module adc_frame_streamer_uart_byte_handshake (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       send_en,
    input  logic       ack_en,
    input  logic [7:0] byte_in,
    input  logic       tx_ready,
    output logic       sent,
    output logic       acked,
    output logic [7:0] tx_data,
    output logic       tx_write_en
);

    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_write_en_q, tx_write_en_d;

    // Strobe once when the UART is ready; the byte is then held until the next strobe.
    always_comb begin
        sent          = send_en & tx_ready;
        acked         = ack_en & ~tx_ready;
        tx_write_en_d = sent;
        tx_data_d     = sent ? byte_in : tx_data_q;
    end

    // Output registers, cleared immediately by reset so a frame in flight is abandoned.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_data_q     <= '0;
            tx_write_en_q <= 1'b0;
        end else begin
            tx_data_q     <= tx_data_d;
            tx_write_en_q <= tx_write_en_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_write_en = tx_write_en_q;

endmodule

// File: rtl/adc_frame_streamer.sv
// rtl/adc_frame_streamer.sv - snapshot N_CH ADC channels and frame them for UART TX (optional FRAME_CHECKSUM_EN)
module adc_frame_streamer
    import adc_frame_streamer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int ADC_W = 10,
    parameter int DECIM = 1
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic [N_CH-1:0]       sample_valid,
    input  logic [N_CH*ADC_W-1:0] sample_data,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_write_en,
    output logic                  busy,
    output logic                  stream_on,
    output logic                  overrun
);

    logic [ADC_W-1:0] shadow_q [N_CH];
    logic [ADC_W-1:0] shadow_d [N_CH];
    logic [ADC_W-1:0] frame_q  [N_CH];
    logic [ADC_W-1:0] frame_d  [N_CH];
    logic [N_CH-1:0]  fresh_q, fresh_d;
    logic             snap_done_q, snap_done_d;
    state_e           state_q, state_d;
    logic [7:0]       sel_q, sel_d;
    logic [4:0]       idx_q, idx_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_sel_q, pend_sel_d;
    logic             stream_on_q, stream_on_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      decim_q, decim_d;

    logic             is_oneshot, stream_fire;
    logic [7:0]       os_sel;
    logic [4:0]       last_idx, k;
    logic [3:0]       ch;
    logic [15:0]      data16;
    logic [7:0]       cur_byte;
    logic             hs_sent, hs_acked;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [4:0] CSUM_BYTES = 5'd1;
    logic [7:0] csum_q, csum_d;

    // Running XOR of every byte after the header, restarted for each frame.
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_LOAD) begin
            csum_d = '0;
        end else if (hs_sent && idx_q != 5'd0) begin
            csum_d = csum_q ^ cur_byte;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) csum_q <= '0;
        else          csum_q <= csum_d;
    end
`else
    localparam logic [4:0] CSUM_BYTES = 5'd0;
`endif

    // Capture: shadow regs and fresh bits; in stream mode a full set is consumed as one snapshot.
    always_comb begin
        fresh_d = fresh_q;
        if (stream_on_q && (&fresh_q)) fresh_d = '0;
        fresh_d     = fresh_d | sample_valid;
        snap_done_d = (&fresh_q) && !(stream_on_q && snap_done_q);
        for (int i = 0; i < N_CH; i++) begin
            shadow_d[i] = sample_valid[i] ? sample_data[i*ADC_W +: ADC_W] : shadow_q[i];
        end
    end

    // Command decode, stream decimation/overrun, pending slot and frame FSM next state.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        pend_valid_d = pend_valid_q;
        pend_sel_d   = pend_sel_q;
        stream_on_d  = stream_on_q;
        overrun_d    = overrun_q;
        decim_d      = decim_q;
        frame_d      = frame_q;
        is_oneshot   = 1'b0;
        os_sel       = SEL_ALL;
        stream_fire  = 1'b0;

        if (snap_done_q && stream_on_q) begin
            if (decim_q == 16'(DECIM - 1)) begin
                decim_d     = '0;
                stream_fire = 1'b1;
            end else begin
                decim_d = decim_q + 16'd1;
            end
            if (state_q != ST_IDLE) overrun_d = 1'b1;
        end

        if (rx_ready) begin
            if (rx_data >= CMD_CH_BASE && rx_data < CMD_CH_BASE + 8'(N_CH)) begin
                is_oneshot = 1'b1;
                os_sel     = rx_data - CMD_CH_BASE;
            end else if (rx_data == CMD_ALL) begin
                is_oneshot = 1'b1;
            end else if (rx_data == CMD_START) begin
                stream_on_d = 1'b1;
                decim_d     = '0;
            end else if (rx_data == CMD_STOP) begin
                stream_on_d = 1'b0;
                overrun_d   = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    sel_d        = pend_sel_q;
                    state_d      = ST_LOAD;
                    pend_valid_d = is_oneshot;
                    pend_sel_d   = is_oneshot ? os_sel : pend_sel_q;
                end else if (is_oneshot) begin
                    sel_d   = os_sel;
                    state_d = ST_LOAD;
                end else if (stream_fire) begin
                    sel_d   = SEL_ALL;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_d = shadow_q;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_sent) state_d = ST_ACK;
            end
            default: begin
                if (hs_acked) begin
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_SEND;
                    end
                end
            end
        endcase

        if (state_q != ST_IDLE && is_oneshot) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = os_sel;
        end
    end

    // Byte selection: header, SEL, then MSB/LSB pairs of the selected channels.
    always_comb begin
        last_idx = ((sel_q == SEL_ALL) ? 5'(1 + 2 * N_CH) : 5'd3) + CSUM_BYTES;
        k        = idx_q - 5'd2;
        ch       = (sel_q == SEL_ALL) ? k[4:1] : sel_q[3:0];
        data16   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (4'(c) == ch) data16 = 16'(frame_q[c]);
        end
        if (idx_q == 5'd0) begin
            cur_byte = FRAME_HDR;
        end else if (idx_q == 5'd1) begin
            cur_byte = sel_q;
`ifdef FRAME_CHECKSUM_EN
        end else if (idx_q == last_idx) begin
            cur_byte = csum_q;
`endif
        end else if (k[0]) begin
            cur_byte = data16[7:0];
        end else begin
            cur_byte = data16[15:8];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
                frame_q[i]  <= '0;
            end
            fresh_q      <= '0;
            snap_done_q  <= 1'b0;
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            stream_on_q  <= 1'b0;
            overrun_q    <= 1'b0;
            decim_q      <= '0;
        end else begin
            shadow_q     <= shadow_d;
            frame_q      <= frame_d;
            fresh_q      <= fresh_d;
            snap_done_q  <= snap_done_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            pend_sel_q   <= pend_sel_d;
            stream_on_q  <= stream_on_d;
            overrun_q    <= overrun_d;
            decim_q      <= decim_d;
        end
    end

    adc_frame_streamer_uart_byte_handshake u_hs (
        .clk         (clk),
        .reset_b     (reset_b),
        .send_en     (state_q == ST_SEND),
        .ack_en      (state_q == ST_ACK),
        .byte_in     (cur_byte),
        .tx_ready    (tx_ready),
        .sent        (hs_sent),
        .acked       (hs_acked),
        .tx_data     (tx_data),
        .tx_write_en (tx_write_en)
    );

    assign busy      = (state_q != ST_IDLE);
    assign stream_on = stream_on_q;
    assign overrun   = overrun_q;

endmodule
